imem_fetch_ctrl: RTL

//  Instruction-fetch sequencer for the 2-cycle-latency, byte-addressed instruction memory (imem).
//  - Owns the fetch PC and drives one word address per cycle into imem.
//  - Tags in-flight reads, then buffers the returned words with their PCs in a small FIFO.
//  - Presents {pc, instr} to decode over a valid/ready handshake.
//  - Handles redirects (branch/jump/trap) and a halt/drain request from the core.

---
 rtl/imem_fetch_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: issues one word address per cycle into a 2-cycle imem, tags reads,
// buffers returned {pc, instr} in a credit-protected FIFO. Optional IFETCH_PERF_EN adds perf counters.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic            tag0_v_q, tag1_v_q;
    logic [31:0]     tag0_pc_q, tag1_pc_q;
    logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [CW-1:0]   occupancy_s;
    logic            credit_ok_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     redirect_target_s;

    // Occupancy includes reads still in the imem pipe so a return can never overflow the FIFO.
    assign occupancy_s       = count_q + CW'(tag0_v_q) + CW'(tag1_v_q);
    assign credit_ok_s       = (occupancy_s < CW'(FIFO_DEPTH));
    assign issue_s           = !halt_req && !redirect_valid && credit_ok_s;
    assign push_s            = tag1_v_q;
    assign pop_s             = out_valid && out_ready;
    assign redirect_target_s = redirect_pc & 32'hFFFF_FFFC;

    assign imem_addr = pc_q;
    assign out_valid = (count_q != CW'(0));
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign halted    = (state_q == ST_HALTED) && halt_req;

    // Run/drain/halt sequencing; dropping halt_req always returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) state_d = ST_DRAIN;
                else          state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!halt_req)                   state_d = ST_RUN;
                else if (!tag0_v_q && !tag1_v_q) state_d = ST_HALTED;
                else                             state_d = ST_DRAIN;
            end
            ST_HALTED: begin
                if (!halt_req) state_d = ST_RUN;
                else           state_d = ST_HALTED;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State register, PC, tag pipeline and output FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            tag0_v_q  <= 1'b0;
            tag1_v_q  <= 1'b0;
            tag0_pc_q <= 32'h0000_0000;
            tag1_pc_q <= 32'h0000_0000;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                // Redirect wins over any same-cycle pop or return.
                pc_q     <= redirect_target_s;
                tag0_v_q <= 1'b0;
                tag1_v_q <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (issue_s) pc_q <= pc_q + 32'd4;
                else         pc_q <= pc_q;
                tag0_v_q  <= issue_s;
                tag0_pc_q <= pc_q;
                tag1_v_q  <= tag0_v_q;
                tag1_pc_q <= tag0_pc_q;
                if (push_s) begin
                    fifo_pc_q[wr_ptr_q]    <= tag1_pc_q;
                    fifo_instr_q[wr_ptr_q] <= imem_data;
                    wr_ptr_q               <= wr_ptr_q + PW'(1);
                end
                if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push_s) - CW'(pop_s);
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic stall_s;
    assign stall_s = (state_q == ST_RUN) && !halt_req && !redirect_valid && !credit_ok_s;

    // Issued-fetch and credit-stall event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0000_0000;
            perf_stall_cnt <= 32'h0000_0000;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(issue_s);
            perf_stall_cnt <= perf_stall_cnt + 32'(stall_s);
        end
    end
`endif

endmodule
